// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU operand / result bundle for the ALU command issuer.
// The issuer owns the master modport; the command source, ALU and result consumer see the slave side.
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [SEL_W-1:0]  cmd_sel;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_result;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [SEL_W-1:0]  res_sel;

    logic [15:0]       op_count;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
               op_count, busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
               op_count, busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives one at a time into an external combinational ALU,
// and returns each captured result with its select code over a valid/ready channel.
module alu_cmd_issuer #(
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.master  bus_if
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q;
    cmd_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] alu_a_q, alu_b_q, res_data_q;
    logic [SEL_W-1:0]  alu_sel_q, res_sel_q;
    logic              res_valid_q;
    logic [15:0]       op_count_q;

    logic full, empty, push, pop, res_fire;
    cmd_t head;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign push     = bus_if.cmd_valid && bus_if.cmd_ready;
    assign res_fire = (state_q == RESP) && res_valid_q && bus_if.res_ready;
    // A pop always coincides with an operand load, either from IDLE or on the
    // accepting edge of RESP so back-to-back commands skip the IDLE cycle.
    assign pop      = !empty && ((state_q == IDLE) || res_fire);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{sel: bus_if.cmd_sel, a: bus_if.cmd_a, b: bus_if.cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        alu_a_q   <= head.a;
                        alu_b_q   <= head.b;
                        alu_sel_q <= head.sel;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= bus_if.alu_result;
                    res_sel_q   <= alu_sel_q;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (res_fire) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        if (!empty) begin
                            alu_a_q   <= head.a;
                            alu_b_q   <= head.b;
                            alu_sel_q <= head.sel;
                            state_q   <= EXEC;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.cmd_ready = rst_n && !full;
    assign bus_if.alu_a     = alu_a_q;
    assign bus_if.alu_b     = alu_b_q;
    assign bus_if.alu_sel   = alu_sel_q;
    assign bus_if.res_valid = res_valid_q;
    assign bus_if.res_data  = res_data_q;
    assign bus_if.res_sel   = res_sel_q;
    assign bus_if.op_count  = op_count_q;
    assign bus_if.busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural 8-bit ALU attached.
// Stimulus queues expected {sel,result}; a negedge monitor checks every accepted result.
module tb_alu_cmd_issuer;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

    alu_cmd_issuer #(.DATA_W(DW), .SEL_W(SW), .FIFO_DEPTH(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    function automatic logic [7:0] alu_ref(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (s)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = (b == 8'd0) ? 8'hFF : a / b;
            4'd4:    r = a << 1;
            4'd5:    r = a >> 1;
            4'd6:    r = {a[6:0], a[7]};
            4'd7:    r = {a[0], a[7:1]};
            4'd8:    r = a & b;
            4'd9:    r = a | b;
            4'd10:   r = a ^ b;
            4'd11:   r = ~(a | b);
            4'd12:   r = ~(a & b);
            4'd13:   r = ~(a ^ b);
            4'd14:   r = (a > b) ? 8'd1 : 8'd0;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return r;
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [11:0] exp_q[$];
    int          hs_q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic [11:0] held, e;
    logic        held_vld = 1'b0;
    logic        rr_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted result is popped from the scoreboard in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_vld = 1'b0;
        end else begin
            chk("op_count", 32'(bus.op_count), 32'(exp_cnt));
            if (bus.res_valid) begin
                if (held_vld) begin
                    chk("hold_data", 32'(bus.res_data), 32'(held[7:0]));
                    chk("hold_sel", 32'(bus.res_sel), 32'(held[11:8]));
                end
                if (bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", 32'(bus.res_data), 32'(e[7:0]));
                        chk("res_sel", 32'(bus.res_sel), 32'(e[11:8]));
                    end
                    exp_cnt = exp_cnt + 16'd1;
                    hs_q.push_back(cyc);
                    held_vld = 1'b0;
                end else begin
                    held = {bus.res_sel, bus.res_data};
                    held_vld = 1'b1;
                end
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    task automatic push(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel = s;
        bus.cmd_a = a;
        bus.cmd_b = b;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("push_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            exp_q.push_back({s, alu_ref(s, a, b)});
            @(posedge clk);
            #1 bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #2 n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        chk({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'd0);
        chk({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
        chk({tag, "_res_sel"}, 32'(bus.res_sel), 32'd0);
        chk({tag, "_op_count"}, 32'(bus.op_count), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] s;
        logic [7:0] a, b;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_sel = '0;
        bus.res_ready = 1'b1;

        // reset state
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // single op latency: accepted at T, res_valid seen after T+2
        @(negedge clk);
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd0; bus.cmd_a = 8'h0A; bus.cmd_b = 8'h03;
        exp_q.push_back({4'd0, alu_ref(4'd0, 8'h0A, 8'h03)});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        chk("lat_t0_res_valid", 32'(bus.res_valid), 32'd0);
        chk("lat_t0_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 chk("lat_t1_alu_a", 32'(bus.alu_a), 32'h0A);
        chk("lat_t1_alu_b", 32'(bus.alu_b), 32'h03);
        chk("lat_t1_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_t2_res_valid", 32'(bus.res_valid), 32'd1);
        chk("lat_t2_res_data", 32'(bus.res_data), 32'h0D);
        chk("lat_t2_res_sel", 32'(bus.res_sel), 32'd0);
        @(posedge clk);
        #1 chk("lat_t3_op_count", 32'(bus.op_count), 32'd1);
        chk("lat_t3_busy", 32'(bus.busy), 32'd0);

        // back-to-back: one result every 2 cycles
        hs_q.delete();
        push(4'd0, 8'h0A, 8'h03);
        push(4'd1, 8'h0A, 8'h03);
        push(4'd8, 8'h0A, 8'h03);
        push(4'd10, 8'h0A, 8'h03);
        drain();
        chk("b2b_count", 32'(hs_q.size()), 32'd4);
        if (hs_q.size() == 4)
            for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(hs_q[i] - hs_q[i-1]), 32'd2);
        chk("b2b_op_count", 32'(bus.op_count), 32'd5);

        // backpressure: 1 in flight + 4 queued, then full-and-pop edge
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'(i + 1), 8'($urandom), 8'($urandom));
        repeat (3) @(negedge clk);
        chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
        chk("bp_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd3; bus.cmd_a = 8'hC8; bus.cmd_b = 8'h07;
        @(posedge clk);
        #1 chk("full_pop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        exp_q.push_back({4'd3, alu_ref(4'd3, 8'hC8, 8'h07)});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        drain();

        // randomized traffic with random result backpressure
        rr_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    s = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) b = 8'd0;
                    push(s, a, b);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                rr_done = 1'b1;
            end
            begin
                while (!rr_done) begin
                    @(posedge clk);
                    #1 bus.res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        drain();

        // counter wrap from 0xFFFF
        repeat (3) @(posedge clk);
        #2 force dut.op_count_q = 16'hFFFF;
        #1 release dut.op_count_q;
        exp_cnt = 16'hFFFF;
        push(4'd2, 8'h11, 8'h03);
        drain();
        @(posedge clk);
        #1 chk("wrap_op_count", 32'(bus.op_count), 32'd0);

        // reset during RESP with 3 queued
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'd9, 8'(i), 8'h40);
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("mid_reach_resp", 32'(bus.res_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        exp_q.delete();
        exp_cnt = 16'd0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
        chk("post_reset_res_valid", 32'(bus.res_valid), 32'd0);
        chk("post_reset_op_count", 32'(bus.op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
